// File: rtl/interrupter_mc_pkg.sv
// Shared constants for the multi-channel interrupter: bus widths and the
// register word offsets inside the 64-word block.
package interrupter_mc_pkg;

    localparam int ADR_W       = 14;
    localparam int DATA_W      = 32;
    localparam int OFS_W       = 6;
    localparam int ID_W        = 6;
    localparam int BLOCK_WORDS = 64;

    typedef enum logic [OFS_W-1:0] {
        REG_PENDING = 6'h00,
        REG_ENABLE  = 6'h01,
        REG_MODE    = 6'h02,
        REG_THRESH  = 6'h03,
        REG_CLAIM   = 6'h04,
        REG_PRIO0   = 6'h08
    } reg_ofs_e;

endpackage

// File: rtl/interrupter_mc_prio_sel.sv
// Priority selector: picks the highest-priority candidate, lowest index on ties.
// win_id is index+1, or 0 when no channel is a candidate.
module irq_prio_sel
    import interrupter_mc_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 3
) (
    input  logic [NUM_IRQ-1:0]             cand,
    input  logic [NUM_IRQ-1:0][PRIO_W-1:0] prio,
    output logic [ID_W-1:0]                win_id,
    output logic [PRIO_W-1:0]              win_prio
);

    // Strict '>' while scanning upward keeps the lowest index on equal priority.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand[i] && (prio[i] > win_prio)) begin
                win_prio = prio[i];
                win_id   = ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/interrupter_mc.sv
// Multi-channel interrupt controller on the word-addressed io bus: synchronisers,
// level/edge gateways, claim/complete handshake and the registered g_interrupt.
module interrupter_mc
    import interrupter_mc_pkg::*;
#(
    parameter int               NUM_IRQ  = 8,
    parameter int               PRIO_W   = 3,
    parameter logic [ADR_W-1:0] BASE_ADR = 14'h3e00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               csr_meie,
    input  logic               io_we,
    input  logic [ADR_W-1:0]   io_wadr,
    input  logic [DATA_W-1:0]  io_wdata,
    input  logic               io_re,
    input  logic [ADR_W-1:0]   io_radr,
    output logic [DATA_W-1:0]  io_rdata,
    output logic               g_interrupt
);

    localparam logic [ADR_W-OFS_W-1:0] BASE_HI = BASE_ADR[ADR_W-1:OFS_W];

    logic [NUM_IRQ-1:0]             sync1, sync2, sync3;
    logic [NUM_IRQ-1:0]             pending, in_service;
    logic [NUM_IRQ-1:0]             enable, mode;
    logic [PRIO_W-1:0]              thresh;
    logic [NUM_IRQ-1:0][PRIO_W-1:0] prio;

    logic [NUM_IRQ-1:0] gw_set, claim_clr, done_clr, cand;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic               wr_hit, rd_hit, claim_rd, claim_wr;
    logic [OFS_W-1:0]   wr_ofs, rd_ofs;
    logic [DATA_W-1:0]  rd_mux;

    assign wr_ofs   = io_wadr[OFS_W-1:0];
    assign rd_ofs   = io_radr[OFS_W-1:0];
    assign wr_hit   = io_we && (io_wadr[ADR_W-1:OFS_W] == BASE_HI);
    assign rd_hit   = io_re && (io_radr[ADR_W-1:OFS_W] == BASE_HI);
    assign claim_rd = rd_hit && (rd_ofs == REG_CLAIM);
    assign claim_wr = wr_hit && (wr_ofs == REG_CLAIM);

    // Completes only act on channels already in service before this edge,
    // so a same-cycle claim+complete of one channel leaves it claimed.
    always_comb begin
        gw_set    = '0;
        claim_clr = '0;
        done_clr  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            gw_set[i]    = mode[i] ? (sync2[i] & ~sync3[i])
                                   : (sync2[i] & ~pending[i] & ~in_service[i]);
            claim_clr[i] = claim_rd && (win_id == ID_W'(i + 1));
            done_clr[i]  = claim_wr && (io_wdata == DATA_W'(i + 1)) && in_service[i];
            cand[i]      = pending[i] & enable[i] & (prio[i] != '0);
        end
    end

    irq_prio_sel #(
        .NUM_IRQ (NUM_IRQ),
        .PRIO_W  (PRIO_W)
    ) u_prio_sel (
        .cand     (cand),
        .prio     (prio),
        .win_id   (win_id),
        .win_prio (win_prio)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
            sync1 <= irq_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // A gateway set overrides the claim clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= (pending & ~claim_clr) | gw_set;
            in_service <= (in_service & ~done_clr) | claim_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable <= '0;
            mode   <= '0;
            thresh <= '0;
            // NOTE: the priority table is reset too, since a nonzero power-up priority could fire spuriously.
            prio   <= '0;
        end else if (wr_hit) begin
            case (wr_ofs)
                REG_ENABLE: enable <= io_wdata[NUM_IRQ-1:0];
                REG_MODE:   mode   <= io_wdata[NUM_IRQ-1:0];
                REG_THRESH: thresh <= io_wdata[PRIO_W-1:0];
                default: begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (wr_ofs == (REG_PRIO0 + OFS_W'(i))) begin
                            prio[i] <= io_wdata[PRIO_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        if (rd_hit) begin
            case (rd_ofs)
                REG_PENDING: rd_mux[NUM_IRQ-1:0] = pending;
                REG_ENABLE:  rd_mux[NUM_IRQ-1:0] = enable;
                REG_MODE:    rd_mux[NUM_IRQ-1:0] = mode;
                REG_THRESH:  rd_mux[PRIO_W-1:0]  = thresh;
                REG_CLAIM:   rd_mux[ID_W-1:0]    = win_id;
                default: begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (rd_ofs == (REG_PRIO0 + OFS_W'(i))) begin
                            rd_mux[PRIO_W-1:0] = prio[i];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata    <= '0;
            g_interrupt <= 1'b0;
        end else begin
            if (io_re) begin
                io_rdata <= rd_mux;
            end
            g_interrupt <= csr_meie & (win_prio > thresh);
        end
    end

endmodule

// File: tb/tb_interrupter_mc.sv
// Directed bench for interrupter_mc: expected read data is queued when a read is
// issued and compared when the data comes back; g_interrupt is checked directly.
module tb_interrupter_mc;

    localparam int          NUM_IRQ = 8;
    localparam logic [13:0] BASE    = 14'h3e00;
    localparam logic [5:0]  O_PEND  = 6'h00;
    localparam logic [5:0]  O_EN    = 6'h01;
    localparam logic [5:0]  O_MODE  = 6'h02;
    localparam logic [5:0]  O_THR   = 6'h03;
    localparam logic [5:0]  O_CLAIM = 6'h04;
    localparam logic [5:0]  O_PRIO0 = 6'h08;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic               csr_meie;
    logic               io_we;
    logic [13:0]        io_wadr;
    logic [31:0]        io_wdata;
    logic               io_re;
    logic [13:0]        io_radr;
    logic [31:0]        io_rdata;
    logic               g_interrupt;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    interrupter_mc #(
        .NUM_IRQ  (NUM_IRQ),
        .PRIO_W   (3),
        .BASE_ADR (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .csr_meie    (csr_meie),
        .io_we       (io_we),
        .io_wadr     (io_wadr),
        .io_wdata    (io_wdata),
        .io_re       (io_re),
        .io_radr     (io_radr),
        .io_rdata    (io_rdata),
        .g_interrupt (g_interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, io_rdata, e.exp);
        end
    endtask

    task automatic wr(input logic [5:0] ofs, input logic [31:0] data);
        io_we    = 1'b1;
        io_wadr  = BASE + 14'(ofs);
        io_wdata = data;
        tick();
        io_we    = 1'b0;
    endtask

    task automatic rd(input logic [5:0] ofs, input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag   = tag;
        e.exp   = exp;
        io_re   = 1'b1;
        io_radr = BASE + 14'(ofs);
        sb.push_back(e);
        tick();
        io_re   = 1'b0;
        pop_check();
    endtask

    task automatic rw(input logic [5:0] wofs, input logic [31:0] data, input logic [5:0] rofs,
                      input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag    = tag;
        e.exp    = exp;
        io_we    = 1'b1;
        io_wadr  = BASE + 14'(wofs);
        io_wdata = data;
        io_re    = 1'b1;
        io_radr  = BASE + 14'(rofs);
        sb.push_back(e);
        tick();
        io_we    = 1'b0;
        io_re    = 1'b0;
        pop_check();
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_in   = '0;
        csr_meie = 1'b0;
        io_we    = 1'b0;
        io_wadr  = '0;
        io_wdata = '0;
        io_re    = 1'b0;
        io_radr  = '0;

        // 1: reset state
        repeat (5) tick();
        check("rst_g", 32'(g_interrupt), 32'd0);
        check("rst_rdata", io_rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        rd(O_PEND, "rst_pending", 32'h0);
        rd(O_EN, "rst_enable", 32'h0);
        rd(O_MODE, "rst_mode", 32'h0);
        rd(O_THR, "rst_thresh", 32'h0);
        rd(O_CLAIM, "rst_claim", 32'h0);
        for (int i = 0; i < NUM_IRQ; i++) rd(O_PRIO0 + 6'(i), "rst_prio", 32'h0);

        // 2: level channel 3 and its latency
        csr_meie = 1'b1;
        wr(O_PRIO0 + 6'd3, 32'd5);
        wr(O_EN, 32'h08);
        irq_in = 8'h08;
        tick();
        check("lvl_e0_g", 32'(g_interrupt), 32'd0);
        tick();
        check("lvl_e1_g", 32'(g_interrupt), 32'd0);
        tick();
        check("lvl_e2_g", 32'(g_interrupt), 32'd0);
        tick();
        check("lvl_e3_g", 32'(g_interrupt), 32'd1);
        rd(O_CLAIM, "lvl_claim", 32'd4);
        check("lvl_g_claim_edge", 32'(g_interrupt), 32'd1);
        tick();
        check("lvl_g_after_claim", 32'(g_interrupt), 32'd0);
        wr(O_CLAIM, 32'd4);
        check("lvl_g_cmp0", 32'(g_interrupt), 32'd0);
        tick();
        check("lvl_g_cmp1", 32'(g_interrupt), 32'd0);
        tick();
        check("lvl_g_cmp2", 32'(g_interrupt), 32'd1);
        irq_in = '0;
        repeat (3) tick();
        rd(O_CLAIM, "lvl_reclaim", 32'd4);
        wr(O_CLAIM, 32'd4);
        rd(O_PEND, "lvl_idle_pending", 32'h0);

        // 3: arbitration and threshold
        wr(O_THR, 32'd7);
        wr(O_PRIO0 + 6'd1, 32'd2);
        wr(O_PRIO0 + 6'd2, 32'd7);
        wr(O_PRIO0 + 6'd6, 32'd7);
        wr(O_EN, 32'h46);
        irq_in = 8'h46;
        repeat (4) tick();
        check("arb_thresh_g", 32'(g_interrupt), 32'd0);
        rd(O_PEND, "arb_pending", 32'h46);
        rd(O_CLAIM, "arb_claim_tie", 32'd3);
        wr(O_THR, 32'd0);
        tick();
        check("arb_g_thr0", 32'(g_interrupt), 32'd1);
        rd(O_CLAIM, "arb_claim_ch6", 32'd7);
        rd(O_CLAIM, "arb_claim_ch1", 32'd2);
        rd(O_CLAIM, "arb_claim_none", 32'd0);
        irq_in = '0;
        repeat (3) tick();
        wr(O_CLAIM, 32'd3);
        wr(O_CLAIM, 32'd7);
        wr(O_CLAIM, 32'd2);
        rd(O_PEND, "arb_idle_pending", 32'h0);

        // 4: edge channel 0
        wr(O_EN, 32'h01);
        wr(O_MODE, 32'h01);
        wr(O_PRIO0, 32'd1);
        irq_in = 8'h01;
        tick();
        irq_in = '0;
        repeat (4) tick();
        rd(O_CLAIM, "edge_claim1", 32'd1);
        irq_in = 8'h01;
        tick();
        irq_in = '0;
        repeat (4) tick();
        rd(O_PEND, "edge_pend_in_service", 32'h01);
        rd(O_CLAIM, "edge_claim2", 32'd1);
        wr(O_CLAIM, 32'd1);
        irq_in = 8'h01;
        repeat (4) tick();
        rd(O_PEND, "edge_held_once", 32'h01);
        rd(O_CLAIM, "edge_claim3", 32'd1);
        wr(O_CLAIM, 32'd1);
        repeat (3) tick();
        rd(O_PEND, "edge_level_ignored", 32'h0);
        irq_in = '0;

        // 5: masking, gating, bad complete ids, register widths
        wr(O_EN, 32'h0);
        wr(O_PRIO0 + 6'd5, 32'd4);
        irq_in = 8'h20;
        repeat (4) tick();
        rd(O_PEND, "mask_pending", 32'h20);
        rd(O_CLAIM, "mask_claim_none", 32'd0);
        rd(O_PEND, "mask_pending_kept", 32'h20);
        check("mask_g", 32'(g_interrupt), 32'd0);
        wr(O_EN, 32'h20);
        tick();
        check("unmask_g", 32'(g_interrupt), 32'd1);
        csr_meie = 1'b0;
        tick();
        check("meie_off_g", 32'(g_interrupt), 32'd0);
        rd(O_PEND, "meie_off_pending", 32'h20);
        rd(O_CLAIM, "meie_off_claim", 32'd6);
        wr(O_CLAIM, 32'd9);
        wr(O_CLAIM, 32'd0);
        repeat (2) tick();
        rd(O_PEND, "bad_id_ignored", 32'h0);
        wr(O_CLAIM, 32'd6);
        tick();
        rd(O_PEND, "good_id_relevel", 32'h20);
        wr(O_EN, 32'hFFFF_FFFF);
        rd(O_EN, "enable_width", 32'h0000_00FF);
        wr(O_PRIO0 + 6'd7, 32'hFFFF_FFFF);
        rd(O_PRIO0 + 6'd7, "prio_width", 32'h7);
        rd(6'h05, "unmapped_read", 32'h0);
        rw(O_THR, 32'd3, O_THR, "rw_old_value", 32'h0);
        rd(O_THR, "rw_new_value", 32'h3);
        wr(O_THR, 32'd0);

        // 6: reset right after a claim
        csr_meie = 1'b1;
        tick();
        check("pre_rst_g", 32'(g_interrupt), 32'd1);
        rd(O_CLAIM, "pre_rst_claim", 32'd6);
        check("pre_rst_g_hold", 32'(g_interrupt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_g", 32'(g_interrupt), 32'd0);
        check("async_rst_rdata", io_rdata, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rd(O_PEND, "post_rst_pending", 32'h0);
        rd(O_EN, "post_rst_enable", 32'h0);
        rd(O_CLAIM, "post_rst_claim", 32'd0);
        wr(O_EN, 32'h20);
        wr(O_PRIO0 + 6'd5, 32'd4);
        repeat (2) tick();
        rd(O_PEND, "post_rst_in_service_clear", 32'h20);
        tick();
        check("post_rst_g", 32'(g_interrupt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
